// File: rtl/clock_enable_sequencer_pkg.sv
// Shared clocking definitions: sequencer state encoding and default widths.
package clock_enable_sequencer_pkg;
  localparam int DEFAULT_CREDIT_WIDTH = 16;
  localparam int DEFAULT_DIV_WIDTH    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } seq_state_t;
endpackage

// File: rtl/clock_enable_sequencer_phase_divider.sv
// Phase counter 0..eff_div-1; flags phase zero. Held at 0 while restart is high,
// and the period is re-latched only at restart or wrap so ratio changes land cleanly.
module enable_phase_divider
  import clock_enable_sequencer_pkg::*;
#(
  parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] eff_div,
  output logic                 phase_zero
);
  logic [DIV_WIDTH-1:0] phase;
  logic [DIV_WIDTH-1:0] period;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase  <= '0;
      period <= DIV_WIDTH'(1);
    end else if (restart) begin
      phase  <= '0;
      period <= eff_div;
    end else if (phase >= period - DIV_WIDTH'(1)) begin
      phase  <= '0;
      period <= eff_div;
    end else begin
      phase <= phase + DIV_WIDTH'(1);
    end
  end

  assign phase_zero = (phase == '0);
endmodule

// File: rtl/clock_enable_sequencer.sv
// Credit-metered clock-enable sequencer: one registered ce pulse per credit every
// eff_div cycles while running; halt freezes issue and keeps credits.
module clock_enable_sequencer
  import clock_enable_sequencer_pkg::*;
#(
  parameter int CREDIT_WIDTH = DEFAULT_CREDIT_WIDTH,
  parameter int DIV_WIDTH    = DEFAULT_DIV_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DIV_WIDTH-1:0]    div_ratio,
  input  logic                    grant_valid,
  input  logic [CREDIT_WIDTH-1:0] grant_count,
  output logic                    grant_ready,
  input  logic                    halt,
  output logic                    ce,
  output logic                    halted,
  output logic [CREDIT_WIDTH-1:0] credits,
  output logic [31:0]             fired_count
);
  seq_state_t              state;
  seq_state_t              state_next;
  logic [DIV_WIDTH-1:0]    eff_div;
  logic                    phase_zero;
  logic                    fire;
  logic                    accept;
  logic [CREDIT_WIDTH:0]   credit_sum;
  logic [CREDIT_WIDTH-1:0] credits_next;

  assign eff_div = (div_ratio == '0) ? DIV_WIDTH'(1) : div_ratio;

  // Readiness ignores the pending decrement, so the sum alone must not carry out.
  assign credit_sum  = {1'b0, credits} + {1'b0, grant_count};
  assign grant_ready = ~credit_sum[CREDIT_WIDTH];
  assign accept      = grant_valid & grant_ready;
  assign fire        = (state == ST_RUN) & phase_zero & ~halt;

  always_comb begin
    credits_next = credits;
    if (accept) credits_next = credit_sum[CREDIT_WIDTH-1:0];
    if (fire)   credits_next = credits_next - CREDIT_WIDTH'(1);
  end

  always_comb begin
    state_next = ST_IDLE;
    if (halt)                    state_next = ST_HALT;
    else if (credits_next != '0) state_next = ST_RUN;
  end

  enable_phase_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_divider (
    .clock      (clock),
    .reset      (reset),
    .restart    (state != ST_RUN),
    .eff_div    (eff_div),
    .phase_zero (phase_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      ce          <= 1'b0;
      halted      <= 1'b0;
      credits     <= '0;
      fired_count <= '0;
    end else begin
      state       <= state_next;
      ce          <= fire;
      halted      <= halt;
      credits     <= credits_next;
      fired_count <= fired_count + 32'(fire);
    end
  end
endmodule

// File: tb/tb_clock_enable_sequencer.sv
// Self-checking bench: directed scenarios plus randomized run against a cycle model.
module tb_clock_enable_sequencer;
  localparam int MAXC = 65535;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  div_ratio = 8'd1;
  logic        grant_valid = 1'b0;
  logic [15:0] grant_count = '0;
  logic        grant_ready;
  logic        halt = 1'b0;
  logic        ce;
  logic        halted;
  logic [15:0] credits;
  logic [31:0] fired_count;

  int checks = 0;
  int failures = 0;

  // Reference model state (integers, cycle-level behaviour of the rules)
  int          m_credits;
  bit          m_active;
  int          m_phase;
  int          m_period;
  bit          m_ce;
  bit          m_halted;
  int unsigned m_fired;

  clock_enable_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .div_ratio   (div_ratio),
    .grant_valid (grant_valid),
    .grant_count (grant_count),
    .grant_ready (grant_ready),
    .halt        (halt),
    .ce          (ce),
    .halted      (halted),
    .credits     (credits),
    .fired_count (fired_count)
  );

  always #5 clock = ~clock;

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    m_credits = 0; m_active = 0; m_phase = 0; m_period = 1;
    m_ce = 0; m_halted = 0; m_fired = 0;
  endtask

  task automatic model_step();
    bit fire;
    bit acc;
    bit now_active;
    fire = m_active && !halt && (m_phase == 0);
    acc  = grant_valid && (m_credits + int'(grant_count) <= MAXC);
    m_credits = m_credits + (acc ? int'(grant_count) : 0) - (fire ? 1 : 0);
    m_ce = fire;
    if (fire) m_fired = m_fired + 1;
    m_halted = halt;
    now_active = !halt && (m_credits > 0);
    if (now_active && m_active) begin
      if (m_phase + 1 >= m_period) begin
        m_phase = 0;
        m_period = eff(int'(div_ratio));
      end else begin
        m_phase = m_phase + 1;
      end
    end else begin
      m_phase = 0;
      m_period = eff(int'(div_ratio));
    end
    m_active = now_active;
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) model_step();
    #1;
  endtask

  task automatic apply_reset();
    grant_valid = 0; grant_count = '0; halt = 0; div_ratio = 8'd1;
    reset = 1;
    @(posedge clock);
    @(negedge clock);
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1;
    grant_count = 16'd5;
    #3;
    checks++;
    if (ce !== 1'b0 || halted !== 1'b0 || credits !== 16'd0 || fired_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: ce=%b halted=%b credits=%0d fired=%0d want 0/0/0/0",
               ce, halted, credits, fired_count);
    end
    checks++;
    if (grant_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b want 1", grant_ready);
    end
    apply_reset();
  endtask

  task automatic test_basic();
    apply_reset();
    div_ratio = 8'd1; grant_valid = 1; grant_count = 16'd5;
    #1;
    checks++;
    if (grant_ready !== 1'b1) begin
      failures++; $display("FAIL basic_ready: got %b want 1", grant_ready);
    end
    tick();
    grant_valid = 0;
    checks++;
    if (ce !== 1'b0 || credits !== 16'd5) begin
      failures++; $display("FAIL basic_t1: ce=%b credits=%0d want 0/5", ce, credits);
    end
    for (int k = 2; k <= 6; k++) begin
      tick();
      checks++;
      if (ce !== 1'b1 || credits !== 16'(6 - k) || fired_count !== 32'(k - 1)) begin
        failures++;
        $display("FAIL basic_t%0d: ce=%b credits=%0d fired=%0d want 1/%0d/%0d",
                 k, ce, credits, fired_count, 6 - k, k - 1);
      end
    end
    tick();
    checks++;
    if (ce !== 1'b0 || credits !== 16'd0 || fired_count !== 32'd5) begin
      failures++;
      $display("FAIL basic_end: ce=%b credits=%0d fired=%0d want 0/0/5", ce, credits, fired_count);
    end
  endtask

  task automatic test_div3();
    int q[$];
    int want[4] = '{2, 5, 8, 11};
    int cyc;
    apply_reset();
    div_ratio = 8'd3; grant_valid = 1; grant_count = 16'd4;
    tick();
    grant_valid = 0;
    cyc = 1;
    repeat (20) begin
      if (ce === 1'b1) q.push_back(cyc);
      tick();
      cyc++;
    end
    checks++;
    if (q.size() != 4) begin
      failures++; $display("FAIL div3_count: got %0d pulses want 4", q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q[i] != want[i]) begin
          failures++; $display("FAIL div3_pulse%0d: cycle %0d want %0d", i, q[i], want[i]);
        end
      end
    end
    checks++;
    if (credits !== 16'd0 || ce !== 1'b0 || fired_count !== 32'd4) begin
      failures++;
      $display("FAIL div3_end: credits=%0d ce=%b fired=%0d want 0/0/4", credits, ce, fired_count);
    end
  endtask

  task automatic test_halt();
    int seen;
    apply_reset();
    div_ratio = 8'd1; grant_valid = 1; grant_count = 16'd10;
    tick();
    grant_valid = 0;
    seen = 0;
    for (int i = 0; i < 20 && seen < 3; i++) begin
      tick();
      if (ce === 1'b1) seen++;
    end
    checks++;
    if (seen != 3) begin
      failures++; $display("FAIL halt_wait: saw %0d pulses want 3", seen);
    end
    halt = 1;
    tick();
    checks++;
    if (ce !== 1'b0 || halted !== 1'b1 || credits !== 16'd7) begin
      failures++;
      $display("FAIL halt_enter: ce=%b halted=%b credits=%0d want 0/1/7", ce, halted, credits);
    end
    repeat (3) tick();
    checks++;
    if (ce !== 1'b0 || credits !== 16'd7) begin
      failures++; $display("FAIL halt_hold: ce=%b credits=%0d want 0/7", ce, credits);
    end
    halt = 0;
    tick();
    checks++;
    if (ce !== 1'b0) begin
      failures++; $display("FAIL halt_resume1: ce=%b want 0", ce);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (ce !== (k < 7 ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL halt_resume_c%0d: ce=%b want %b", k, ce, k < 7);
      end
    end
    checks++;
    if (fired_count !== 32'd10 || halted !== 1'b0) begin
      failures++;
      $display("FAIL halt_end: fired=%0d halted=%b want 10/0", fired_count, halted);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    halt = 1; grant_valid = 1; grant_count = 16'hFFF0;
    #1;
    checks++;
    if (grant_ready !== 1'b1) begin
      failures++; $display("FAIL ovf_first_ready: got %b want 1", grant_ready);
    end
    tick();
    grant_count = 16'h0020;
    #1;
    checks++;
    if (grant_ready !== 1'b0 || credits !== 16'hFFF0 || halted !== 1'b1) begin
      failures++;
      $display("FAIL ovf_big: ready=%b credits=%h halted=%b want 0/fff0/1",
               grant_ready, credits, halted);
    end
    tick();
    grant_count = 16'h000F;
    #1;
    checks++;
    if (grant_ready !== 1'b1 || credits !== 16'hFFF0) begin
      failures++;
      $display("FAIL ovf_fit: ready=%b credits=%h want 1/fff0", grant_ready, credits);
    end
    tick();
    grant_count = 16'h0000;
    #1;
    checks++;
    if (grant_ready !== 1'b1 || credits !== 16'hFFFF) begin
      failures++;
      $display("FAIL ovf_full: ready=%b credits=%h want 1/ffff", grant_ready, credits);
    end
    tick();
    grant_count = 16'h0001;
    #1;
    checks++;
    if (grant_ready !== 1'b0 || credits !== 16'hFFFF) begin
      failures++;
      $display("FAIL ovf_zero_grant: ready=%b credits=%h want 0/ffff", grant_ready, credits);
    end
    tick();
    checks++;
    if (credits !== 16'hFFFF || ce !== 1'b0) begin
      failures++; $display("FAIL ovf_end: credits=%h ce=%b want ffff/0", credits, ce);
    end
    grant_valid = 0; halt = 0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    div_ratio = 8'd1; grant_valid = 1; grant_count = 16'd20;
    tick();
    grant_valid = 0;
    repeat (4) tick();
    checks++;
    if (ce !== 1'b1) begin
      failures++; $display("FAIL areset_running: ce=%b want 1", ce);
    end
    #2 reset = 1;
    #1;
    checks++;
    if (ce !== 1'b0 || credits !== 16'd0 || fired_count !== 32'd0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL areset_immediate: ce=%b credits=%0d fired=%0d want 0/0/0",
               ce, credits, fired_count);
    end
    @(posedge clock);
    #3 reset = 0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (ce !== 1'b0 || credits !== 16'd0) begin
        failures++;
        $display("FAIL areset_after%0d: ce=%b credits=%0d want 0/0", k, ce, credits);
      end
    end
  endtask

  task automatic test_div0();
    apply_reset();
    div_ratio = 8'd0; grant_valid = 1; grant_count = 16'd3;
    tick();
    grant_valid = 0;
    for (int k = 2; k <= 5; k++) begin
      tick();
      checks++;
      if (ce !== (k <= 4 ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL div0_t%0d: ce=%b want %b", k, ce, k <= 4);
      end
    end
    checks++;
    if (fired_count !== 32'd3) begin
      failures++; $display("FAIL div0_fired: got %0d want 3", fired_count);
    end
  endtask

  task automatic test_random();
    bit want_ready;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 99) < 5) div_ratio = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 99) < 4) halt = ~halt;
      grant_valid = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 10) grant_count = 16'($urandom_range(0, MAXC));
      else grant_count = 16'($urandom_range(0, 6));
      #1;
      want_ready = (m_credits + int'(grant_count) <= MAXC);
      checks++;
      if (grant_ready !== want_ready) begin
        failures++;
        $display("FAIL rand_ready c%0d: got %b want %b", c, grant_ready, want_ready);
      end
      tick();
      checks++;
      if (ce !== m_ce || halted !== m_halted || credits !== 16'(m_credits)
          || fired_count !== m_fired) begin
        failures++;
        $display("FAIL rand_out c%0d: ce=%b halted=%b credits=%0d fired=%0d want %b/%b/%0d/%0d",
                 c, ce, halted, credits, fired_count, m_ce, m_halted, m_credits, m_fired);
      end
    end
    grant_valid = 0; halt = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_div3();
    test_halt();
    test_overflow();
    test_async_reset();
    test_div0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
